// File: rtl/imm_extend_stage.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_stage
// Description : Registered, mode-selectable immediate extender and branch
//               target generator for the ID stage, with a ready/valid
//               handshake on both sides plus stall and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extend_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int IMM_WIDTH  = 16,
    parameter int PC_WIDTH   = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_instruccion,
    input  logic [1:0]            i_mode,
    input  logic [PC_WIDTH-1:0]   i_pc_plus4,
    input  logic                  i_flush,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_immediate,
    output logic [DATA_WIDTH-1:0] o_branchoffset,
    output logic [PC_WIDTH-1:0]   o_branchtarget
);

    localparam int        c_ext_width = DATA_WIDTH - IMM_WIDTH;

    localparam logic [1:0] c_mode_sign   = 2'b00;
    localparam logic [1:0] c_mode_zero   = 2'b01;
    localparam logic [1:0] c_mode_upper  = 2'b10;
    localparam logic [1:0] c_mode_branch = 2'b11;

    localparam logic [0:0] c_st_empty = 1'b0;
    localparam logic [0:0] c_st_full  = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] imm_q, imm_d;
    logic [DATA_WIDTH-1:0] off_q, off_d;
    logic [PC_WIDTH-1:0]   tgt_q, tgt_d;

    logic                  w_accept;
    logic                  w_transfer;
    logic [IMM_WIDTH-1:0]  w_imm;
    logic [DATA_WIDTH-1:0] w_sign_ext;
    logic [DATA_WIDTH-1:0] w_zero_ext;
    logic [DATA_WIDTH-1:0] w_upper_ext;
    logic [DATA_WIDTH-1:0] w_sel_ext;
    logic [DATA_WIDTH-1:0] w_offset;
    logic [PC_WIDTH-1:0]   w_offset_pc;
    logic [PC_WIDTH-1:0]   w_target;

    // ------------------------------------------------------------------
    // Extension datapath (feeds only the output registers)
    // ------------------------------------------------------------------
    assign w_imm       = i_instruccion[IMM_WIDTH-1:0];
    assign w_sign_ext  = {{c_ext_width{w_imm[IMM_WIDTH-1]}}, w_imm};
    assign w_zero_ext  = {{c_ext_width{1'b0}}, w_imm};
    assign w_upper_ext = {w_imm, {c_ext_width{1'b0}}};
    assign w_offset    = {w_sign_ext[DATA_WIDTH-3:0], 2'b00};

    always_comb begin
        w_sel_ext = w_sign_ext;
        case (i_mode)
            c_mode_sign:   w_sel_ext = w_sign_ext;
            c_mode_zero:   w_sel_ext = w_zero_ext;
            c_mode_upper:  w_sel_ext = w_upper_ext;
            c_mode_branch: w_sel_ext = w_sign_ext;
            default:       w_sel_ext = w_sign_ext;
        endcase
    end

    // The offset is a signed quantity, so widening to the PC must sign-extend.
    generate
        if (PC_WIDTH > DATA_WIDTH) begin : g_pc_sext
            assign w_offset_pc = {{(PC_WIDTH-DATA_WIDTH){w_offset[DATA_WIDTH-1]}}, w_offset};
        end else if (PC_WIDTH < DATA_WIDTH) begin : g_pc_trunc
            assign w_offset_pc = w_offset[PC_WIDTH-1:0];
        end else begin : g_pc_same
            assign w_offset_pc = w_offset;
        end
    endgenerate

    assign w_target = i_pc_plus4 + w_offset_pc;

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    assign o_ready    = (state_q == c_st_empty) || i_ready;
    assign w_accept   = i_valid && o_ready && !i_flush;
    assign w_transfer = (state_q == c_st_full) && i_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= c_st_empty;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; flush outranks both accept and transfer
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_empty: begin
                if (w_accept) begin
                    state_d = c_st_full;
                end
            end
            c_st_full: begin
                if (i_flush) begin
                    state_d = c_st_empty;
                end else if (w_transfer && !w_accept) begin
                    state_d = c_st_empty;
                end
            end
            default: state_d = c_st_empty;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        o_valid = 1'b0;
        case (state_q)
            c_st_empty: o_valid = 1'b0;
            c_st_full:  o_valid = 1'b1;
            default:    o_valid = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Result registers: load only on accept, otherwise hold
    // ------------------------------------------------------------------
    always_comb begin
        imm_d = imm_q;
        off_d = off_q;
        tgt_d = tgt_q;
        if (w_accept) begin
            imm_d = w_sel_ext;
            off_d = w_offset;
            tgt_d = w_target;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            imm_q <= '0;
            off_q <= '0;
            tgt_q <= '0;
        end else begin
            imm_q <= imm_d;
            off_q <= off_d;
            tgt_q <= tgt_d;
        end
    end

    assign o_immediate    = imm_q;
    assign o_branchoffset = off_q;
    assign o_branchtarget = tgt_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_extend_stage
// Description : Self-checking bench for imm_extend_stage (default widths).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_extend_stage;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr;
    logic [1:0]  i_mode;
    logic [31:0] i_pc;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_imm;
    logic [31:0] o_off;
    logic [31:0] o_tgt;

    int n_checks = 0;
    int n_errors = 0;
    int dut_xfer = 0;
    int xfer_base;

    imm_extend_stage #(
        .DATA_WIDTH(32),
        .IMM_WIDTH (16),
        .PC_WIDTH  (32)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_instruccion (i_instr),
        .i_mode        (i_mode),
        .i_pc_plus4    (i_pc),
        .i_flush       (i_flush),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_immediate   (o_imm),
        .o_branchoffset(o_off),
        .o_branchtarget(o_tgt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: signed 16-bit value as an integer.
    function automatic int sval(input logic [31:0] instr);
        int v;
        v = int'(instr & 32'h0000FFFF);
        if (v >= 32768) v = v - 65536;
        return v;
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] instr, input logic [1:0] mode);
        int u;
        u = int'(instr & 32'h0000FFFF);
        case (mode)
            2'b01:   return 32'(u);
            2'b10:   return 32'(u * 65536);
            default: return 32'(sval(instr));
        endcase
    endfunction

    function automatic logic [31:0] ref_off(input logic [31:0] instr);
        return 32'(sval(instr) * 4);
    endfunction

    // Behavioural model of the stage's contents
    logic        m_valid;
    logic [31:0] m_imm, m_off, m_tgt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_imm   <= '0;
            m_off   <= '0;
            m_tgt   <= '0;
        end else if (i_flush) begin
            m_valid <= 1'b0;
        end else if (i_valid && (!m_valid || i_ready)) begin
            m_valid <= 1'b1;
            m_imm   <= ref_imm(i_instr, i_mode);
            m_off   <= ref_off(i_instr);
            m_tgt   <= i_pc + ref_off(i_instr);
        end else if (m_valid && i_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst_n && o_valid && i_ready && !i_flush) dut_xfer++;
    end

    // Continuous compare against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_valid", {31'd0, o_valid}, {31'd0, m_valid});
            chk("model_ready", {31'd0, o_ready}, {31'd0, (!m_valid || i_ready)});
            if (m_valid && o_valid) begin
                chk("model_imm", o_imm, m_imm);
                chk("model_off", o_off, m_off);
                chk("model_tgt", o_tgt, m_tgt);
            end
        end
    end

    task automatic send(input logic [31:0] instr, input logic [1:0] mode, input logic [31:0] pc);
        i_valid = 1'b1;
        i_instr = instr;
        i_mode  = mode;
        i_pc    = pc;
        @(posedge clk);
        #2;
        i_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] mode_exp [4];
    logic [31:0] stream   [4];

    initial begin
        mode_exp[0] = 32'hFFFF9240;
        mode_exp[1] = 32'h00009240;
        mode_exp[2] = 32'h92400000;
        mode_exp[3] = 32'hFFFF9240;
        stream[0] = 32'h00000002;
        stream[1] = 32'h00000003;
        stream[2] = 32'h00008004;
        stream[3] = 32'h00000005;

        rst_n = 1'b0; i_valid = 1'b0; i_instr = '0; i_mode = 2'b00;
        i_pc = '0; i_flush = 1'b0; i_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", {31'd0, o_valid}, 32'd0);
        chk("reset_imm", o_imm, 32'd0);
        chk("reset_tgt", o_tgt, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, o_ready}, 32'd1);
        #1;

        // All four modes on the same instruction
        for (int m = 0; m < 4; m++) begin
            send(32'h00009240, 2'(m), 32'h00000100);
            @(negedge clk);
            chk("mode_valid", {31'd0, o_valid}, 32'd1);
            chk("mode_imm", o_imm, mode_exp[m]);
            chk("mode_off", o_off, 32'hFFFE4900);
            #1;
        end
        chk("branch_tgt", o_tgt, 32'hFFFE4A00);

        send(32'h00001240, 2'b00, 32'h00000000);
        @(negedge clk);
        chk("pos_imm", o_imm, 32'h00001240);
        chk("pos_off", o_off, 32'h00004900);
        #1;

        send(32'h00000001, 2'b11, 32'hFFFFFFFC);
        @(negedge clk);
        chk("wrap_tgt", o_tgt, 32'h00000000);
        #1;

        // Stall for three cycles, then stream back to back
        @(posedge clk); #2;
        i_ready = 1'b0;
        xfer_base = dut_xfer;
        send(32'h00001111, 2'b00, 32'h00000000);
        i_valid = 1'b1; i_instr = 32'h00000001; i_mode = 2'b00; i_pc = 32'h10;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_ready", {31'd0, o_ready}, 32'd0);
            chk("stall_imm", o_imm, 32'h00001111);
        end
        #1;
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #2;
            i_instr = stream[k];
        end
        @(posedge clk); #2;
        i_valid = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("stream_count", 32'(dut_xfer - xfer_base), 32'd6);

        // Flush while full with a new instruction offered
        i_ready = 1'b0;
        send(32'h00000077, 2'b01, 32'h0);
        i_flush = 1'b1; i_valid = 1'b1; i_instr = 32'h00000099;
        @(posedge clk); #2;
        i_flush = 1'b0; i_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", {31'd0, o_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("flush_not_captured", {31'd0, o_valid}, 32'd0);
        #1;

        // Asynchronous reset while holding a result
        send(32'h00009240, 2'b11, 32'h00000100);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, o_valid}, 32'd0);
        chk("async_rst_imm", o_imm, 32'd0);
        chk("async_rst_off", o_off, 32'd0);
        chk("async_rst_tgt", o_tgt, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_release_valid", {31'd0, o_valid}, 32'd0);
        #1;
        i_ready = 1'b1;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
